// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, fetch-stage state encoding and reset constants.
package cpu_pkg;

  localparam logic [15:0] RESET_PC = 16'd1;
  localparam logic [8:0]  BUBBLE   = 9'h000;

  // 5-bit opcode space; only HALT_OP has meaning inside the fetch stage.
  localparam logic [4:0] NOP_OP  = 5'b00000;
  localparam logic [4:0] ADD_OP  = 5'b00001;
  localparam logic [4:0] SUB_OP  = 5'b00010;
  localparam logic [4:0] LOAD_OP = 5'b00100;
  localparam logic [4:0] STOR_OP = 5'b00101;
  localparam logic [4:0] BEQ_OP  = 5'b01000;
  localparam logic [4:0] JMP_OP  = 5'b01001;
  localparam logic [4:0] HALT_OP = 5'b11010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [8:0] inst);
    return inst[8:4] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, loads the IF/ID register from the ROM,
// and handles start, stall, redirect and halt draining.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [15:0]  pc,
  input  logic [8:0]   instruction,
  input  logic         stall,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  input  logic         halt_commit,
  output logic         if_valid,
  output logic [8:0]   if_inst,
  output logic [15:0]  if_pc,
  output logic         halted,
  output logic [15:0]  fetch_count,
  output fetch_state_t state
);

  // Handshake: there is no valid/ready pair here; stall is a level that freezes
  // pc and IF/ID for the cycle it is sampled high, and redirect/halt_commit are
  // single-cycle requests acted on at the edge that samples them.

  fetch_state_t state_next;
  logic [15:0]  pc_next;
  logic         valid_next;
  logic [8:0]   inst_next;
  logic [15:0]  if_pc_next;
  logic [15:0]  count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = if_valid;
    inst_next  = if_inst;
    if_pc_next = if_pc;
    count_next = fetch_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = RESET_PC;
        end
      end
      RUN, DRAIN: begin
        if (halt_commit) begin
          state_next = HALTED;
          valid_next = 1'b0;
        end else if (redirect) begin
          // Flush the wrong-path slot; a speculative halt in DRAIN is dropped too.
          state_next = RUN;
          pc_next    = redirect_pc;
          valid_next = 1'b0;
          inst_next  = BUBBLE;
        end else if (!stall) begin
          if (state == RUN) begin
            valid_next = 1'b1;
            inst_next  = instruction;
            if_pc_next = pc;
            count_next = fetch_count + 16'd1;
            if (is_halt(instruction)) state_next = DRAIN;
            else                      pc_next    = pc + 16'd1;
          end else begin
            valid_next = 1'b0;
            inst_next  = BUBBLE;
          end
        end
      end
      HALTED: begin
        if (start) begin
          state_next = RUN;
          pc_next    = RESET_PC;
          count_next = 16'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= BUBBLE;
      if_pc       <= 16'd0;
      fetch_count <= 16'd0;
    end else begin
      pc          <= pc_next;
      if_valid    <= valid_next;
      if_inst     <= inst_next;
      if_pc       <= if_pc_next;
      fetch_count <= count_next;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small behavioural ROM next to the stage.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [15:0]  pc;
  logic [8:0]   instruction;
  logic         stall;
  logic         redirect;
  logic [15:0]  redirect_pc;
  logic         halt_commit;
  logic         if_valid;
  logic [8:0]   if_inst;
  logic [15:0]  if_pc;
  logic         halted;
  logic [15:0]  fetch_count;
  fetch_state_t state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc          (pc),
    .instruction (instruction),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_commit (halt_commit),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .halted      (halted),
    .fetch_count (fetch_count),
    .state       (state)
  );

  // ROM: halts at 25 and 79, ADD with the low address nibble elsewhere.
  function automatic logic [8:0] rom(input logic [15:0] a);
    if (a == 16'd25 || a == 16'd79) return {HALT_OP, 4'h0};
    return {ADD_OP, a[3:0]};
  endfunction

  assign instruction = rom(pc);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic v, input logic [8:0] inst,
                          input logic [15:0] ipc, input logic [15:0] cnt);
    check({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    check({tag, ".if_inst"}, 32'(if_inst), 32'(inst));
    check({tag, ".if_pc"}, 32'(if_pc), 32'(ipc));
    check({tag, ".fetch_count"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 16'd0; halt_commit = 1'b0;
    #12;
    check("rst.pc", 32'(pc), 32'd1);
    check("rst.state", 32'(state), 32'(IDLE));
    check("rst.halted", 32'(halted), 32'd0);
    check_if("rst", 1'b0, 9'h000, 16'd0, 16'd0);
    rst_n = 1'b1;
    tick();

    // redirect in IDLE is ignored
    redirect = 1'b1; redirect_pc = 16'd40;
    tick();
    redirect = 1'b0;
    check("idle_redir.pc", 32'(pc), 32'd1);
    check("idle_redir.state", 32'(state), 32'(IDLE));

    // start and three sequential fetches
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start.pc", 32'(pc), 32'd1);
    check("start.valid", 32'(if_valid), 32'd0);
    tick();
    check_if("f1", 1'b1, 9'h011, 16'd1, 16'd1);
    tick();
    check_if("f2", 1'b1, 9'h012, 16'd2, 16'd2);
    tick();
    check_if("f3", 1'b1, 9'h013, 16'd3, 16'd3);
    check("f3.pc", 32'(pc), 32'd4);

    // stall two cycles at pc=5
    tick();
    check("pre_stall.pc", 32'(pc), 32'd5);
    stall = 1'b1;
    tick();
    tick();
    check("stall.pc", 32'(pc), 32'd5);
    check_if("stall", 1'b1, 9'h014, 16'd4, 16'd4);
    stall = 1'b0;
    tick();
    check_if("resume", 1'b1, 9'h015, 16'd5, 16'd5);

    // redirect to 60, then to 68 while at pc=60
    redirect = 1'b1; redirect_pc = 16'd60;
    tick();
    check("redir60.pc", 32'(pc), 32'd60);
    redirect_pc = 16'd68;
    tick();
    redirect = 1'b0;
    check("redir68.pc", 32'(pc), 32'd68);
    check_if("redir68.bubble", 1'b0, 9'h000, 16'd5, 16'd5);
    tick();
    check_if("redir68.tgt", 1'b1, 9'h014, 16'd68, 16'd6);

    // run into the halt at 79
    redirect = 1'b1; redirect_pc = 16'd77;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tick();
    check_if("halt_fetch", 1'b1, 9'h1A0, 16'd79, 16'd9);
    check("halt_fetch.pc", 32'(pc), 32'd79);
    check("halt_fetch.state", 32'(state), 32'(DRAIN));
    tick();
    check_if("drain", 1'b0, 9'h000, 16'd79, 16'd9);
    check("drain.pc", 32'(pc), 32'd79);
    check("drain.halted", 32'(halted), 32'd0);
    halt_commit = 1'b1;
    tick();
    halt_commit = 1'b0;
    check("commit.halted", 32'(halted), 32'd1);
    check("commit.state", 32'(state), 32'(HALTED));
    tick();
    check("halted.pc", 32'(pc), 32'd79);
    check("halted.valid", 32'(if_valid), 32'd0);

    // restart from HALTED
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart.pc", 32'(pc), 32'd1);
    check("restart.halted", 32'(halted), 32'd0);
    check("restart.count", 32'(fetch_count), 32'd0);
    tick();
    check_if("restart.f1", 1'b1, 9'h011, 16'd1, 16'd1);

    // halt at 25 cancelled by redirect to 30 while draining
    redirect = 1'b1; redirect_pc = 16'd24;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    check("halt25.state", 32'(state), 32'(DRAIN));
    check("halt25.count", 32'(fetch_count), 32'd3);
    redirect = 1'b1; redirect_pc = 16'd30;
    tick();
    redirect = 1'b0;
    check("drain_redir.state", 32'(state), 32'(RUN));
    check("drain_redir.pc", 32'(pc), 32'd30);
    check("drain_redir.halted", 32'(halted), 32'd0);
    tick();
    check_if("drain_redir.tgt", 1'b1, 9'h01E, 16'd30, 16'd4);

    // redirect beats stall, and pc wraps past 16'hFFFF
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    check("redir_stall.pc", 32'(pc), 32'hFFFF);
    check("redir_stall.valid", 32'(if_valid), 32'd0);
    stall = 1'b0; redirect = 1'b0;
    tick();
    check_if("wrap", 1'b1, 9'h01F, 16'hFFFF, 16'd5);
    check("wrap.pc", 32'(pc), 32'h0000);

    // asynchronous reset mid-run, away from any clock edge
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async.pc", 32'(pc), 32'd1);
    check("async.state", 32'(state), 32'(IDLE));
    check("async.halted", 32'(halted), 32'd0);
    check_if("async", 1'b0, 9'h000, 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. Holds the program counter and drives it into the instruction ROM. Captures the returned 9-bit instruction into the IF/ID pipeline register for the decode stage. Handles start, stall, branch/jump redirect and halt draining.

## Interface
- RESET_PC, 16'd1: first fetch address; program memory starts at 1.
- HALT_OP, 5'b11010: opcode that ends fetching.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins fetching from RESET_PC when in IDLE or HALTED.
- pc  out  16  fetch address, driven to the ROM.
- instruction  in  9  ROM output for `pc`, combinational; {opcode[8:4], operand[3:0]}.
- stall  in  1  decode/hazard stall; holds `pc` and the IF/ID register.
- redirect  in  1  taken branch or jump from execute.
- redirect_pc  in  16  target of the redirect.
- halt_commit  in  1  halt instruction has retired downstream.
- if_valid  out  1  IF/ID holds a real instruction.
- if_inst  out  9  IF/ID instruction.
- if_pc  out  16  address of `if_inst`.
- halted  out  1  program finished.
- fetch_count  out  16  number of instructions issued (IF/ID loads with valid=1).

## Operation
- States:
  - IDLE: reset state, no fetch.
  - RUN: fetching.
  - DRAIN: halt fetched; pc frozen; waiting for commit or redirect.
  - HALTED: done.
- IDLE:
  - `start` -> RUN, pc=RESET_PC.
  - IF/ID stays invalid.
- RUN, no stall, no redirect:
  - if_inst<=instruction, if_pc<=pc, if_valid<=1, fetch_count++.
  - If instruction[8:4]==HALT_OP: pc holds and state -> DRAIN.
  - Otherwise pc<=pc+1.
- DRAIN:
  - pc holds. When not stalled, IF/ID loads a bubble: valid=0, inst=9'h000.
  - `halt_commit` -> HALTED.
  - `redirect` -> RUN with the redirect rules below; the halt was speculative.
- HALTED:
  - halted=1; pc and IF/ID hold, IF/ID invalid.
  - `start` -> RUN, pc=RESET_PC, halted=0, fetch_count=0.
- Redirect (RUN or DRAIN):
  - pc<=redirect_pc; IF/ID <= bubble, flushing the wrong-path instruction.
  - fetch_count is not incremented.
- Priority, highest first: rst_n, halt_commit, redirect, stall, normal fetch.
  - Redirect overrides stall.
  - Redirect in the same cycle a halt is fetched: stay RUN, halt discarded.
- `start` in RUN or DRAIN is ignored.
- pc arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000. fetch_count also wraps.
- `redirect` and `halt_commit` in IDLE or HALTED are ignored.

## Timing
- Reset values: pc=RESET_PC, if_valid=0, if_inst=0, if_pc=0, halted=0, fetch_count=0, state IDLE.
- Latency:
  - `start` at edge t: the instruction at address 1 is in IF/ID after edge t+1.
  - One instruction per cycle thereafter.
- Redirect at edge t: pc=target after t; target instruction valid in IF/ID after t+1, giving one bubble cycle.
- Stall is sampled each edge; while high, every output except halted holds its value.
- halted rises on the edge that samples `halt_commit`.
- Reset mid-operation: all state returns to reset values immediately; no partial fetch survives.

## Structure
- Shared package `cpu_pkg` holds:
  - the 5-bit opcode constants, including HALT_OP;
  - the fetch state enum (IDLE, RUN, DRAIN, HALTED);
  - RESET_PC;
  - the bubble encoding 9'h000.
- Single module; no sub-module needed. The ROM is instantiated outside the stage, alongside it.

## Test plan
- Reset then `start`, ROM words 1..3 = non-halt: if_pc goes 1,2,3 on consecutive cycles, if_valid=1, fetch_count=3.
- Stall high for 2 cycles at pc=5: pc stays 5; if_inst/if_pc hold at address 4; resumes at 5 after release.
- Redirect to 16'd68 while at pc=60: one bubble (if_valid=0); next if_pc=68; fetch_count not incremented by the flushed slot.
- Halt at address 79: pc freezes at 79, then bubbles. `halt_commit` gives halted=1 next edge. `start` restarts at pc=1 with fetch_count=0.
- Halt fetched, then redirect to 16'd30 in DRAIN: state RUN, if_pc=30, halted stays 0.
- Same-cycle cases:
  - redirect and stall: redirect wins.
  - redirect_pc=16'hFFFF: pc wraps to 16'h0000.
  - rst_n low mid-run: all outputs return to reset values asynchronously.
